// File: rtl/tfhe_pkg.sv
// tfhe_pkg: shared collector state type and LWE length helper.
package tfhe_pkg;
  typedef enum logic {FILL, DRAIN} state_t;
  function automatic int lwe_len(input int k, input int n);
    return k * n + 1;
  endfunction
endpackage

// File: rtl/simple_dp_bram.sv
// simple_dp_bram: one write port, one registered read port, no reset.
module simple_dp_bram #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  parameter int AW = 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/lwe_sample_collector.sv
// lwe_sample_collector: gathers out-of-order LWE words, then streams them in index order.
module lwe_sample_collector
  import tfhe_pkg::*;
#(
  parameter int K_PARAM = 1,
  parameter int N_PARAM = 1,
  parameter int VALUE_SIZE = 32,
  parameter int ADDR_SIZE = 32,
  localparam int LEN = lwe_len(K_PARAM, N_PARAM),
  localparam int IW = $clog2(LEN)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  valid_data_in,
  input  logic [ADDR_SIZE-1:0]  addr_in,
  input  logic [VALUE_SIZE-1:0] data_in,
  output logic                  ready_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [IW-1:0]         index_out,
  output logic [VALUE_SIZE-1:0] data_out,
  output logic                  last_out,
  output logic                  range_err,
  output logic                  dup_err,
  output logic                  overflow_err
);
  localparam int CW = $clog2(LEN + 1);
  localparam logic [ADDR_SIZE-1:0] LEN_A = ADDR_SIZE'(LEN);
  localparam logic [IW:0] LEN_P = (IW + 1)'(LEN);
  localparam logic [IW-1:0] LAST = IW'(LEN - 1);
  state_t state, state_n;
  logic [CW-1:0] count;
  logic [LEN-1:0] written;
  logic [IW:0] rd_ptr;
  logic pend, skid_v;
  logic [IW-1:0] pend_idx, skid_idx, widx;
  logic [VALUE_SIZE-1:0] skid_data, q;
  logic in_rng, wr, is_dup, pop, done, issue;
  logic [1:0] occ;
  assign ready_out = state == FILL;
  assign last_out = valid_out && index_out == LAST;
  assign widx = addr_in[IW-1:0];
  always_comb begin
    in_rng = addr_in < LEN_A;
    wr = valid_data_in && ready_out && in_rng;
    is_dup = written[widx];
    pop = valid_out && ready_in;
    done = pop && last_out;
    // entries held after this edge, counting the read already in flight
    occ = 2'(valid_out) + 2'(skid_v) + 2'(pend) - 2'(pop);
    issue = state == DRAIN && rd_ptr < LEN_P && occ < 2'd2;
    state_n = (wr && !is_dup && count == CW'(LEN - 1)) ? DRAIN : done ? FILL : state;
  end
  simple_dp_bram #(.DEPTH(LEN), .WIDTH(VALUE_SIZE), .AW(IW)) u_buf (
    .clk(clk_in),
    .we(wr),
    .waddr(widx),
    .wdata(data_in),
    .raddr(rd_ptr[IW-1:0]),
    .rdata(q)
  );
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= FILL;
      count <= '0;
      written <= '0;
      rd_ptr <= '0;
      pend <= 1'b0;
      pend_idx <= '0;
      skid_v <= 1'b0;
      skid_idx <= '0;
      skid_data <= '0;
      valid_out <= 1'b0;
      index_out <= '0;
      data_out <= '0;
      range_err <= 1'b0;
      dup_err <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      state <= state_n;
      range_err <= range_err | (valid_data_in && ready_out && !in_rng);
      dup_err <= dup_err | (wr && is_dup);
      overflow_err <= overflow_err | (valid_data_in && !ready_out);
      if (done) begin
        count <= '0;
        written <= '0;
        rd_ptr <= '0;
        pend <= 1'b0;
        skid_v <= 1'b0;
        valid_out <= 1'b0;
      end else begin
        if (wr) begin
          written[widx] <= 1'b1;
          count <= count + CW'(!is_dup);
        end
        if (issue) rd_ptr <= rd_ptr + 1'b1;
        pend <= issue;
        pend_idx <= rd_ptr[IW-1:0];
        // skid entry is always older than the word arriving from the buffer
        if (!valid_out || pop) begin
          valid_out <= skid_v | pend;
          if (skid_v | pend) begin
            index_out <= skid_v ? skid_idx : pend_idx;
            data_out <= skid_v ? skid_data : q;
          end
          skid_v <= skid_v & pend;
          skid_idx <= pend_idx;
          skid_data <= q;
        end else if (pend) begin
          skid_v <= 1'b1;
          skid_idx <= pend_idx;
          skid_data <= q;
        end
      end
    end
  end
endmodule

// File: tb/tb_lwe_sample_collector.sv
// tb_lwe_sample_collector: randomized scoreboard bench for the LWE collector (K=1, N=4).
module tb_lwe_sample_collector;
  localparam int LEN = 5;
  localparam int IW = 3;
  logic clk_in = 1'b0;
  logic rst_in, valid_data_in, ready_in, ready_out, valid_out, last_out;
  logic range_err, dup_err, overflow_err;
  logic [31:0] addr_in, data_in, data_out;
  logic [IW-1:0] index_out;

  lwe_sample_collector #(.K_PARAM(1), .N_PARAM(4), .VALUE_SIZE(32), .ADDR_SIZE(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_data_in(valid_data_in), .addr_in(addr_in),
    .data_in(data_in), .ready_out(ready_out), .valid_out(valid_out), .ready_in(ready_in),
    .index_out(index_out), .data_out(data_out), .last_out(last_out),
    .range_err(range_err), .dup_err(dup_err), .overflow_err(overflow_err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {int idx; logic [31:0] data;} exp_t;
  exp_t exp_q[$];
  int n_checks = 0, n_fail = 0, cyc = 0, mode = 0, m_cnt = 0, t_first = 0, t_last = 0;
  logic [31:0] m_mem [LEN];
  bit m_wr [LEN];
  bit fill_now = 1, fill_next = 1;
  logic [2:0] exp_flags = '0, pend_flags = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_cnt = 0;
    foreach (m_wr[i]) m_wr[i] = 0;
    fill_now = 1;
    fill_next = 1;
    exp_flags = '0;
    pend_flags = '0;
  endtask

  // one clock of stimulus; the model tracks what the collector must do with the word
  task automatic present(input bit v, input int a, input logic [31:0] d);
    @(posedge clk_in);
    #1;
    exp_flags |= pend_flags;
    pend_flags = '0;
    fill_now = fill_next;
    cyc++;
    ready_in = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
    valid_data_in = v;
    addr_in = 32'(a);
    data_in = d;
    if (v) begin
      if (!fill_now) pend_flags[0] = 1'b1;
      else if (a >= LEN) pend_flags[2] = 1'b1;
      else begin
        if (m_wr[a]) pend_flags[1] = 1'b1;
        else m_cnt++;
        m_wr[a] = 1;
        m_mem[a] = d;
        if (m_cnt == LEN) begin
          for (int i = 0; i < LEN; i++) exp_q.push_back('{i, m_mem[i]});
          m_cnt = 0;
          foreach (m_wr[i]) m_wr[i] = 0;
          fill_next = 0;
        end
      end
    end
  endtask

  task automatic reset_now();
    rst_in = 1'b1;
    valid_data_in = 1'b0;
    model_clear();
    #1;
    check("rst_valid_out", valid_out, 0);
    check("rst_last_out", last_out, 0);
    check("rst_index_out", index_out, 0);
    check("rst_data_out", data_out, 0);
    check("rst_flags", {range_err, dup_err, overflow_err}, 0);
    check("rst_ready_out", ready_out, 1);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  task automatic fill(input logic [31:0] base);
    for (int a = 0; a < LEN; a++) present(1, a, base + 32'(a));
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((exp_q.size() != 0 || !fill_next) && k < 60) begin
      present(0, 0, 0);
      k++;
    end
    check("drain_done_in_time", k < 60, 1);
    present(0, 0, 0);
  endtask

  initial begin : mon
    bit stall = 0, seen = 0, s_last = 0;
    logic [IW-1:0] s_idx = '0;
    logic [31:0] s_data = '0;
    int dcyc = 0;
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        stall = 0;
        seen = 0;
        dcyc = 0;
      end else begin
        check("ready_out", ready_out, fill_now);
        check("err_flags", {range_err, dup_err, overflow_err}, exp_flags);
        if (stall) begin
          check("stall_valid", valid_out, 1);
          check("stall_index", index_out, s_idx);
          check("stall_data", data_out, s_data);
          check("stall_last", last_out, s_last);
        end
        if (fill_now) begin
          dcyc = 0;
          seen = 0;
        end else if (!seen) begin
          dcyc++;
          if (valid_out || dcyc > 3) begin
            seen = 1;
            check("first_valid_latency", dcyc <= 3, 1);
          end
        end
        if (valid_out && ready_in) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: index %0d data %h with nothing expected", index_out, data_out);
          end else begin
            e = exp_q.pop_front();
            check("drain_index", index_out, e.idx);
            check("drain_data", data_out, e.data);
            check("drain_last", last_out, e.idx == LEN - 1);
            if (e.idx == 0) t_first = cyc;
            if (e.idx == LEN - 1) begin
              t_last = cyc;
              fill_next = 1;
            end
          end
        end
        stall = valid_out && !ready_in;
        s_idx = index_out;
        s_data = data_out;
        s_last = last_out;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    valid_data_in = 1'b0;
    addr_in = '0;
    data_in = '0;
    ready_in = 1'b1;
    reset_now();
    mode = 0;
    for (int a = 4; a >= 0; a--) present(1, a, 32'hA0 + 32'(a));
    wait_drain();
    check("full_rate_drain", t_last - t_first, LEN - 1);
    reset_now();
    mode = 1;
    for (int a = 4; a >= 0; a--) present(1, a, 32'hA0 + 32'(a));
    wait_drain();
    reset_now();
    mode = 0;
    present(1, 2, 32'h11);
    present(1, 2, 32'h22);
    present(1, 0, 32'h10);
    present(1, 1, 32'h12);
    present(1, 3, 32'h13);
    present(1, 4, 32'h14);
    wait_drain();
    reset_now();
    present(1, 7, 32'h77);
    fill(32'hC0);
    wait_drain();
    reset_now();
    fill(32'hE0);
    present(1, 1, 32'hFF);
    present(1, 3, 32'hEE);
    wait_drain();
    reset_now();
    mode = 1;
    fill(32'hD0);
    k = 0;
    while (!(valid_out && index_out == 2) && k < 30) begin
      present(0, 0, 0);
      k++;
    end
    check("reached_index2", k < 30, 1);
    reset_now();
    mode = 0;
    fill(32'hB0);
    wait_drain();
    reset_now();
    mode = 2;
    repeat (400) present($urandom_range(0, 3) != 0, $urandom_range(0, 6), $urandom);
    k = 0;
    while (!fill_next && k < 60) begin
      present(0, 0, 0);
      k++;
    end
    for (int a = 0; a < LEN; a++) present(1, a, $urandom);
    wait_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
